// File: rtl/pixel_usb_packer.sv
// pixel_usb_packer: buffers 16-bit readout pixels in a FIFO and streams them low byte first to an FT245 write port.
module pixel_usb_packer #(
    parameter int DEPTH    = 16,
    parameter int WR_PULSE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [15:0]              pix_data,
    input  logic                     pix_avail,
    output logic                     pix_accept,
    input  logic                     ft_txe_n,
    output logic                     ft_wr_n,
    output logic [7:0]               ft_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     clear_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] ACC_MAX = (AW+1)'(DEPTH - 2);
    typedef enum logic [2:0] {IDLE, WAIT, SETUP, STROBE, HOLD} state_t;
    logic          r_av1, r_av2, r_av3, r_tx1, r_tx2;
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          r_accept, r_ovf;
    state_t        r_state, w_n_state;
    logic [15:0]   r_shift, w_n_shift;
    logic          r_sel, w_n_sel;
    logic [2:0]    r_cnt, w_n_cnt;
    logic          r_wr_n, w_n_wr_n;
    logic [7:0]    r_data, w_n_data;
    logic          w_cap, w_full, w_push, w_drop, w_pop;
    assign w_cap  = enable & r_av2 & ~r_av3;
    assign w_full = r_count == FULL;
    assign w_push = w_cap & ~w_full;
    assign w_drop = w_cap & w_full;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_av1, r_av2, r_av3, r_tx1, r_tx2} <= '0;
        end else begin
            {r_av1, r_av2, r_av3} <= {pix_avail, r_av1, r_av2};
            {r_tx1, r_tx2}        <= {ft_txe_n, r_tx1};
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= pix_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_accept <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wptr   <= r_wptr + AW'(w_push);
            r_rptr   <= r_rptr + AW'(w_pop);
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_accept <= r_count <= ACC_MAX;
            r_ovf    <= w_drop ? 1'b1 : clear_ovf ? 1'b0 : r_ovf;
        end
    end
    always_comb begin
        w_n_state = r_state;
        w_n_shift = r_shift;
        w_n_sel   = r_sel;
        w_n_cnt   = r_cnt;
        w_n_wr_n  = r_wr_n;
        w_n_data  = r_data;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: if (r_count != '0) begin
                w_pop     = 1'b1;
                w_n_shift = r_mem[r_rptr];
                w_n_sel   = 1'b0;
                w_n_state = WAIT;
            end
            WAIT: if (!r_tx2) begin
                w_n_data  = r_sel ? r_shift[15:8] : r_shift[7:0];
                w_n_state = SETUP;
            end
            SETUP: begin
                w_n_wr_n  = 1'b0;
                w_n_cnt   = 3'd1;
                w_n_state = STROBE;
            end
            STROBE: if (r_cnt == 3'(WR_PULSE)) begin
                w_n_wr_n  = 1'b1;
                w_n_state = HOLD;
            end else begin
                w_n_cnt   = r_cnt + 3'd1;
            end
            HOLD: begin
                w_n_sel   = ~r_sel;
                w_n_state = r_sel ? IDLE : WAIT;
            end
            default: w_n_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_sel   <= 1'b0;
            r_cnt   <= '0;
            r_wr_n  <= 1'b1;
            r_data  <= '0;
        end else begin
            r_state <= w_n_state;
            r_shift <= w_n_shift;
            r_sel   <= w_n_sel;
            r_cnt   <= w_n_cnt;
            r_wr_n  <= w_n_wr_n;
            r_data  <= w_n_data;
        end
    end
    assign pix_accept = r_accept;
    assign ft_wr_n    = r_wr_n;
    assign ft_data    = r_data;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;
endmodule

// File: tb/tb_pixel_usb_packer.sv
// tb_pixel_usb_packer: directed bench with a byte-stream scoreboard checking every FT245 strobe.
module tb_pixel_usb_packer;
    localparam int DEPTH = 16;
    localparam int WR_PULSE = 2;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b1, pix_avail = 1'b0, ft_txe_n = 1'b0, clear_ovf = 1'b0;
    logic [15:0] pix_data = '0;
    logic        pix_accept, ft_wr_n, overflow;
    logic [7:0]  ft_data;
    logic [4:0]  fifo_count;
    int          checks = 0, errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  log_b[$];
    logic [7:0]  lit[4] = '{8'hB2, 8'hA1, 8'h04, 8'h03};
    pixel_usb_packer #(.DEPTH(DEPTH), .WR_PULSE(WR_PULSE)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pix_data(pix_data), .pix_avail(pix_avail),
        .pix_accept(pix_accept), .ft_txe_n(ft_txe_n), .ft_wr_n(ft_wr_n), .ft_data(ft_data),
        .fifo_count(fifo_count), .overflow(overflow), .clear_ovf(clear_ovf)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, req);
        end
    endtask
    // Scoreboard: each falling strobe must carry the next expected byte, set up and held around a WR_PULSE-long pulse.
    bit         in_low = 0;
    int         low_cnt = 0;
    logic [7:0] prev_data = '0, latched = '0;
    always @(negedge clk) begin
        if (rst) begin
            in_low = 0;
            low_cnt = 0;
        end else if (!ft_wr_n && !in_low) begin
            in_low = 1;
            low_cnt = 1;
            latched = ft_data;
            log_b.push_back(ft_data);
            chk("setup_data", ft_data, prev_data);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_byte actual %0h required none", ft_data);
            end else chk("byte", ft_data, exp_q.pop_front());
        end else if (!ft_wr_n) begin
            low_cnt++;
            chk("strobe_data", ft_data, latched);
        end else if (in_low) begin
            in_low = 0;
            chk("pulse_len", low_cnt, WR_PULSE);
            chk("hold_data", ft_data, latched);
        end
        prev_data = ft_data;
    end
    task automatic send_px(input logic [15:0] v, input bit keep, input bit clr);
        if (keep) begin
            exp_q.push_back(v[7:0]);
            exp_q.push_back(v[15:8]);
        end
        @(posedge clk); #1;
        pix_data = v;
        pix_avail = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear_ovf = clr;
        @(posedge clk);
        #1 clear_ovf = 1'b0;
        @(posedge clk);
        #1 pix_avail = 1'b0;
        repeat (4) @(posedge clk);
    endtask
    task automatic wait_level(input logic lvl, input string nm);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ft_wr_n !== lvl && n < 300);
        chk(nm, ft_wr_n, lvl);
    endtask
    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !ft_wr_n) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1 chk("drain_left", exp_q.size(), 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1, "watchdog");
    end
    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_accept", pix_accept, 0);
        chk("rst_wr_n", ft_wr_n, 1);
        chk("rst_data", ft_data, 0);
        @(negedge clk) rst = 1'b0;
        #1 chk("accept_pre", pix_accept, 0);
        @(posedge clk); #1;
        chk("accept_post", pix_accept, 1);
        enable = 1'b0;
        send_px(16'hDEAD, 0, 0);
        chk("disabled_count", fifo_count, 0);
        enable = 1'b1;
        send_px(16'hA1B2, 1, 0);
        send_px(16'h0304, 1, 0);
        drain();
        chk("log_len1", log_b.size(), 4);
        for (int i = 0; i < 4; i++) chk("lit_byte", log_b[i], lit[i]);
        fork
            send_px(16'hC0DE, 1, 0);
            begin
                wait_level(0, "lowbyte_fall");
                ft_txe_n = 1'b1;
            end
        join
        repeat (10) begin
            @(posedge clk); #1;
            chk("wait_hold", ft_wr_n, 1);
        end
        chk("log_len_wait", log_b.size(), 5);
        ft_txe_n = 1'b0;
        drain();
        chk("log_len2", log_b.size(), 6);
        chk("hi_byte", log_b[5], 8'hC0);
        ft_txe_n = 1'b1;
        repeat (4) @(posedge clk);
        send_px(16'h1234, 1, 0);
        chk("held_count", fifo_count, 0);
        for (int i = 1; i <= 14; i++) send_px(16'h1000 + 16'(i), 1, 0);
        chk("count14", fifo_count, 14);
        chk("accept14", pix_accept, 1);
        send_px(16'h100F, 1, 0);
        chk("count15", fifo_count, 15);
        chk("accept15", pix_accept, 0);
        send_px(16'h1010, 1, 0);
        chk("count16", fifo_count, 16);
        chk("ovf_before", overflow, 0);
        send_px(16'hBAD0, 0, 0);
        chk("count_full", fifo_count, 16);
        chk("ovf_set", overflow, 1);
        chk("accept_full", pix_accept, 0);
        @(posedge clk); #1 clear_ovf = 1'b1;
        @(posedge clk); #1 clear_ovf = 1'b0;
        chk("ovf_clear", overflow, 0);
        send_px(16'hBAD1, 0, 1);
        chk("ovf_clr_drop", overflow, 1);
        @(posedge clk); #1 clear_ovf = 1'b1;
        @(posedge clk); #1 clear_ovf = 1'b0;
        ft_txe_n = 1'b0;
        drain();
        chk("count_empty", fifo_count, 0);
        ft_txe_n = 1'b1;
        repeat (4) @(posedge clk);
        send_px(16'h2222, 1, 0);
        send_px(16'h3331, 1, 0);
        send_px(16'h3332, 1, 0);
        send_px(16'h3333, 1, 0);
        chk("count3", fifo_count, 3);
        ft_txe_n = 1'b0;
        wait_level(0, "lo_fall");
        wait_level(1, "lo_rise");
        wait_level(0, "hi_fall");
        @(posedge clk); #1;
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h44);
        pix_data = 16'h4444;
        pix_avail = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("pp_before", fifo_count, 3);
        @(posedge clk); #1;
        chk("pp_same", fifo_count, 3);
        @(posedge clk); #1;
        chk("pp_after", fifo_count, 3);
        pix_avail = 1'b0;
        drain();
        fork
            send_px(16'h5555, 1, 0);
            begin
                wait_level(0, "rst_fall");
                #2 rst = 1'b1;
                #1;
                chk("rst_mid_wr_n", ft_wr_n, 1);
                chk("rst_mid_count", fifo_count, 0);
                exp_q.delete();
            end
        join
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        n0 = log_b.size();
        send_px(16'h5A6B, 1, 0);
        drain();
        chk("post_rst_lo", log_b[n0], 8'h6B);
        chk("post_rst_hi", log_b[n0+1], 8'h5A);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
